// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard sequencer:
//               FSM state encoding and EX operand forwarding select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    // Sequencer states: normal issue, or holding the pipe for a multi-cycle MDU op
    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MDU_WAIT = 1'b1
    } hz_state_t;

    // EX operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;  // value read from the register file
    localparam logic [1:0] FWD_MEM = 2'b01;  // result sitting in EX/MEM
    localparam logic [1:0] FWD_WB  = 2'b10;  // result sitting in MEM/WB

endpackage : hazard_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_fwd_unit
// Description : Combinational operand forwarding select for one EX source
//               operand. The younger result (EX/MEM) wins over MEM/WB, and x0
//               is never forwarded since it is hard-wired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_wen_i,
    input  logic [4:0] wb_rd_i,
    input  logic       wb_wen_i,
    output logic [1:0] sel_o
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = mem_wen_i && (mem_rd_i != 5'd0) && (mem_rd_i == rs_i);
    assign w_wb_hit  = wb_wen_i  && (wb_rd_i  != 5'd0) && (wb_rd_i  == rs_i);

    // Select the most recent producer of the operand
    always_comb begin
        sel_o = FWD_RF;
        if (w_mem_hit) begin
            sel_o = FWD_MEM;
        end else if (w_wb_hit) begin
            sel_o = FWD_WB;
        end
    end

endmodule : hazard_ctrl_fwd_unit
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline sequencer for the 5-stage core. Handles load-use
//               stalls, operand forwarding, EX-resolved branch/jump flushes
//               and the multi-cycle MDU hand-shake. Keeps saturating stall
//               and flush performance counters and a sticky MDU timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MDU_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_cpu,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_use,
    input  logic             id_rs2_use,
    input  logic [4:0]       ex_rd,
    input  logic             ex_wen,
    input  logic             ex_load,
    input  logic             ex_mdu,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             mem_wen,
    input  logic             wb_wen,
    input  logic             ex_flush,
    input  logic             mdu_done,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mdu_start,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mdu_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                 c_TMO_W   = $clog2(MDU_TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(MDU_TIMEOUT);
    localparam logic [c_TMO_W-1:0] c_TMO_ONE = c_TMO_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE = CNT_W'(1);

    hz_state_t          r_state_q;
    hz_state_t          w_state_d;
    logic [c_TMO_W-1:0] r_tmo_q;
    logic [c_TMO_W-1:0] w_tmo_d;
    logic               r_err_q;
    logic               w_err_d;
    logic               r_guard_q;
    logic               w_guard_d;
    logic [CNT_W-1:0]   r_stall_cnt_q;
    logic [CNT_W-1:0]   r_flush_cnt_q;

    logic               w_lu;
    logic               w_flush_acc;
    logic               w_release;
    logic [1:0]         w_fwd_a;
    logic [1:0]         w_fwd_b;

    // ------------------------------------------------------------------
    // Forwarding for both EX operands
    // ------------------------------------------------------------------
    hazard_ctrl_fwd_unit u_fwd_a (
        .rs_i      (ex_rs1),
        .mem_rd_i  (mem_rd),
        .mem_wen_i (mem_wen),
        .wb_rd_i   (wb_rd),
        .wb_wen_i  (wb_wen),
        .sel_o     (w_fwd_a)
    );

    hazard_ctrl_fwd_unit u_fwd_b (
        .rs_i      (ex_rs2),
        .mem_rd_i  (mem_rd),
        .mem_wen_i (mem_wen),
        .wb_rd_i   (wb_rd),
        .wb_wen_i  (wb_wen),
        .sel_o     (w_fwd_b)
    );

    // Forwarding is forced to the register file while the core is in reset
    assign fwd_a = rst_cpu ? FWD_RF : w_fwd_a;
    assign fwd_b = rst_cpu ? FWD_RF : w_fwd_b;

    // A load result is not available until MEM, so a dependent ID instruction must wait
    assign w_lu = ex_load && ex_wen && (ex_rd != 5'd0) &&
                  ((id_rs1_use && (id_rs1 == ex_rd)) ||
                   (id_rs2_use && (id_rs2 == ex_rd)));

    // Next-state and control outputs; flush outranks MDU issue outranks load-use
    always_comb begin
        w_state_d    = r_state_q;
        w_tmo_d      = r_tmo_q;
        w_err_d      = r_err_q;
        w_flush_acc  = 1'b0;
        w_release    = 1'b0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mdu_start    = 1'b0;

        case (r_state_q)
            ST_RUN: begin
                if (ex_flush) begin
                    // Younger instructions are wrong-path: squash them, no stall needed
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    w_flush_acc = 1'b1;
                end else if (ex_mdu && !r_guard_q) begin
                    mdu_start    = 1'b1;
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_flush = 1'b1;
                    w_tmo_d      = '0;
                    w_state_d    = ST_MDU_WAIT;
                end else if (w_lu) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end
            ST_MDU_WAIT: begin
                if (mdu_done) begin
                    // Result is valid now: let it flow into EX/MEM this cycle
                    w_release = 1'b1;
                    w_state_d = ST_RUN;
                end else begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_flush = 1'b1;
                    if (r_tmo_q != c_TMO_MAX) begin
                        w_tmo_d = r_tmo_q + c_TMO_ONE;
                    end
                    if (w_tmo_d == c_TMO_MAX) begin
                        w_err_d = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = ST_RUN;
            end
        endcase

        if (rst_cpu) begin
            w_flush_acc  = 1'b0;
            w_release    = 1'b0;
            pc_stall     = 1'b0;
            if_id_stall  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_stall  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b0;
            mdu_start    = 1'b0;
        end
    end

    // The finished MDU op is still in EX right after release; block its re-issue once
    always_comb begin
        w_guard_d = r_guard_q;
        if (w_release) begin
            w_guard_d = 1'b1;
        end else if (!id_ex_stall) begin
            w_guard_d = 1'b0;
        end
    end

    // State, timeout, sticky error and issue-guard registers
    always_ff @(posedge clk) begin
        if (rst_cpu) begin
            r_state_q <= ST_RUN;
            r_tmo_q   <= '0;
            r_err_q   <= 1'b0;
            r_guard_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_tmo_q   <= w_tmo_d;
            r_err_q   <= w_err_d;
            r_guard_q <= w_guard_d;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst_cpu) begin
            r_stall_cnt_q <= '0;
            r_flush_cnt_q <= '0;
        end else begin
            if (pc_stall && !(&r_stall_cnt_q)) begin
                r_stall_cnt_q <= r_stall_cnt_q + c_CNT_ONE;
            end
            if (w_flush_acc && !(&r_flush_cnt_q)) begin
                r_flush_cnt_q <= r_flush_cnt_q + c_CNT_ONE;
            end
        end
    end

    assign mdu_err   = r_err_q;
    assign stall_cnt = r_stall_cnt_q;
    assign flush_cnt = r_flush_cnt_q;

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl: directed scenarios with
//               literal expectations, then randomized traffic compared every
//               cycle against a behavioural model of the sequencing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int CW  = 4;
    localparam int TMO = 8;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_cpu;
    logic [4:0]    id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
    logic          id_rs1_use, id_rs2_use, ex_wen, ex_load, ex_mdu;
    logic          mem_wen, wb_wen, ex_flush, mdu_done;
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic          ex_mem_flush, mdu_start, mdu_err;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.CNT_W(CW), .MDU_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_cpu(rst_cpu),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
        .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_load(ex_load), .ex_mdu(ex_mdu),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_wen(mem_wen), .wb_wen(wb_wen), .ex_flush(ex_flush), .mdu_done(mdu_done),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .mdu_start(mdu_start), .fwd_a(fwd_a), .fwd_b(fwd_b), .mdu_err(mdu_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: MDU busy flag, wait length, error, re-issue block,
    // performance counters as plain integers.
    // ------------------------------------------------------------------
    bit m_busy  = 0;
    bit m_err   = 0;
    bit m_block = 0;
    int m_wait  = 0;
    int m_stall = 0;
    int m_flush = 0;

    function automatic logic [1:0] fwd_of(input logic [4:0] rs);
        if (mem_wen && mem_rd != 0 && mem_rd == rs) return 2'b01;
        if (wb_wen && wb_rd != 0 && wb_rd == rs)    return 2'b10;
        return 2'b00;
    endfunction

    always @(negedge clk) begin : p_cmp
        bit e_pcs, e_ifs, e_iff, e_ids, e_idf, e_emf, e_st, lu, rel;
        logic [1:0] ea, eb;
        e_pcs = 0; e_ifs = 0; e_iff = 0; e_ids = 0; e_idf = 0; e_emf = 0; e_st = 0;
        rel = 0;
        ea = 2'b00; eb = 2'b00;
        lu = ex_load && ex_wen && ex_rd != 0 &&
             ((id_rs1_use && id_rs1 == ex_rd) || (id_rs2_use && id_rs2 == ex_rd));
        if (!rst_cpu) begin
            ea = fwd_of(ex_rs1);
            eb = fwd_of(ex_rs2);
            if (!m_busy) begin
                if (ex_flush) begin
                    e_iff = 1; e_idf = 1;
                end else if (ex_mdu && !m_block) begin
                    e_st = 1; e_pcs = 1; e_ifs = 1; e_ids = 1; e_emf = 1;
                end else if (lu) begin
                    e_pcs = 1; e_ifs = 1; e_idf = 1;
                end
            end else if (mdu_done) begin
                rel = 1;
            end else begin
                e_pcs = 1; e_ifs = 1; e_ids = 1; e_emf = 1;
            end
        end

        chk("pc_stall",     pc_stall,     e_pcs);
        chk("if_id_stall",  if_id_stall,  e_ifs);
        chk("if_id_flush",  if_id_flush,  e_iff);
        chk("id_ex_stall",  id_ex_stall,  e_ids);
        chk("id_ex_flush",  id_ex_flush,  e_idf);
        chk("ex_mem_flush", ex_mem_flush, e_emf);
        chk("mdu_start",    mdu_start,    e_st);
        chk("fwd_a",        fwd_a,        ea);
        chk("fwd_b",        fwd_b,        eb);
        chk("mdu_err",      mdu_err,      m_err);
        chk("stall_cnt",    stall_cnt,    m_stall);
        chk("flush_cnt",    flush_cnt,    m_flush);
        if (mdu_start === 1'b1) n_start++;

        // advance the model to the state after the coming clock edge
        if (rst_cpu) begin
            m_busy = 0; m_err = 0; m_block = 0; m_wait = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!m_busy && ex_flush && m_flush < SAT) m_flush++;
            if (e_pcs && m_stall < SAT) m_stall++;
            if (!m_busy && e_st) begin
                m_busy = 1; m_wait = 0;
            end else if (m_busy && rel) begin
                m_busy = 0;
            end else if (m_busy) begin
                m_wait++;
                if (m_wait >= TMO) m_err = 1;
            end
            if (rel) m_block = 1;
            else if (!e_ids) m_block = 0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic probe();
        @(negedge clk); #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; id_rs1_use = 0; id_rs2_use = 0;
        ex_rd = 0; ex_wen = 0; ex_load = 0; ex_mdu = 0; ex_rs1 = 0; ex_rs2 = 0;
        mem_rd = 0; wb_rd = 0; mem_wen = 0; wb_wen = 0; ex_flush = 0; mdu_done = 0;
    endtask

    task automatic do_reset();
        rst_cpu = 1;
        clear_inputs();
        step(); step();
        rst_cpu = 0;
    endtask

    task automatic set_lu();
        ex_load = 1; ex_wen = 1; ex_rd = 5;
        id_rs1 = 5; id_rs1_use = 1; id_rs2 = 1; id_rs2_use = 1;
    endtask

    task automatic rand_inputs();
        rst_cpu    = ($urandom_range(0, 63) == 0);
        id_rs1     = 5'($urandom_range(0, 3));
        id_rs2     = 5'($urandom_range(0, 3));
        id_rs1_use = 1'($urandom_range(0, 1));
        id_rs2_use = 1'($urandom_range(0, 1));
        ex_rd      = 5'($urandom_range(0, 3));
        ex_wen     = 1'($urandom_range(0, 1));
        ex_load    = 1'($urandom_range(0, 1));
        ex_mdu     = ($urandom_range(0, 5) == 0);
        ex_rs1     = 5'($urandom_range(0, 3));
        ex_rs2     = 5'($urandom_range(0, 3));
        mem_rd     = 5'($urandom_range(0, 3));
        wb_rd      = 5'($urandom_range(0, 3));
        mem_wen    = 1'($urandom_range(0, 1));
        wb_wen     = 1'($urandom_range(0, 1));
        ex_flush   = ($urandom_range(0, 7) == 0);
        mdu_done   = ($urandom_range(0, 5) == 0);
    endtask

    initial begin : p_main
        int s0;
        rst_cpu = 1;
        clear_inputs();
        step(); step();

        // reset state
        probe();
        chk("rst_pc_stall", pc_stall, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        rst_cpu = 0;
        step();

        // 1: load-use stall for one cycle
        do_reset();
        set_lu();
        probe();
        chk("lu_pc_stall", pc_stall, 1);
        chk("lu_id_ex_flush", id_ex_flush, 1);
        step();
        ex_load = 0;
        probe();
        chk("lu_release", pc_stall, 0);
        chk("lu_stall_cnt", stall_cnt, 1);
        step();

        // 2: forwarding priority and x0
        clear_inputs();
        ex_rs1 = 3; mem_rd = 3; mem_wen = 1; wb_rd = 3; wb_wen = 1;
        probe();
        chk("fwd_mem_wins", fwd_a, 2'b01);
        step();
        mem_wen = 0;
        probe();
        chk("fwd_wb", fwd_a, 2'b10);
        step();
        ex_rs1 = 0; mem_rd = 0; wb_rd = 0; mem_wen = 1;
        probe();
        chk("fwd_x0", fwd_a, 2'b00);
        step();

        // 3: flush beats load-use
        do_reset();
        set_lu();
        ex_flush = 1;
        probe();
        chk("fl_if_id_flush", if_id_flush, 1);
        chk("fl_id_ex_flush", id_ex_flush, 1);
        chk("fl_pc_stall", pc_stall, 0);
        step();
        clear_inputs();
        probe();
        chk("fl_flush_cnt", flush_cnt, 1);
        step();

        // 4: MDU op, done on the 6th cycle after issue, no re-issue
        do_reset();
        s0 = n_start;
        ex_mdu = 1;
        probe();
        chk("mdu_start", mdu_start, 1);
        for (int k = 1; k <= 5; k++) begin
            step();
            probe();
            chk("mdu_hold", pc_stall, 1);
        end
        step();
        mdu_done = 1;
        probe();
        chk("mdu_rel_stall", pc_stall, 0);
        chk("mdu_rel_exmem", ex_mem_flush, 0);
        step();
        mdu_done = 0;
        probe();
        chk("mdu_guard", mdu_start, 0);
        chk("mdu_stall_cnt", stall_cnt, 6);
        step();
        ex_mdu = 0;
        probe();
        chk("mdu_one_start", n_start - s0, 1);
        step();

        // 5: MDU timeout and reset recovery
        do_reset();
        ex_mdu = 1;
        step();
        ex_mdu = 0;
        for (int k = 1; k <= TMO; k++) begin
            probe();
            chk("tmo_pending", mdu_err, 0);
            step();
        end
        probe();
        chk("tmo_err", mdu_err, 1);
        chk("tmo_still_wait", pc_stall, 1);
        step();
        rst_cpu = 1;
        probe();
        chk("tmo_rst_stall", pc_stall, 0);
        step();
        rst_cpu = 0;
        probe();
        chk("tmo_err_clr", mdu_err, 0);
        chk("tmo_run", id_ex_stall, 0);
        step();

        // 6: stall counter saturation
        do_reset();
        set_lu();
        repeat (20) step();
        probe();
        chk("sat_stall_cnt", stall_cnt, SAT);
        step();

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end
        rst_cpu = 0;
        clear_inputs();
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
